// File: rtl/phase_encoder.sv
// Phase encoder: maps packed 2-bit phase codes to decimal words and streams them.
// Optional sticky overrun status is built when PHASE_ENC_STATUS_EN is defined.
module phase_encoder #(
  parameter int N_phases = 2'd3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [2*N_phases-1:0]   phase_binary,
  output logic [5*N_phases-1:0]   phase_decimal,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              out_data,
  output logic [1:0]              out_index,
  output logic                    out_last,
`ifdef PHASE_ENC_STATUS_EN
  output logic                    overrun,
`endif
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST = 2'(N_phases - 1);

  state_t state, state_nxt;
  logic [1:0] index, index_nxt;
  logic [5*N_phases-1:0] decoded;
  logic [4:0] field;

  function automatic logic [4:0] encode(input logic [1:0] code);
    logic [4:0] w;
    unique case (code)
      2'b00:   w = 5'd0;
      2'b01:   w = 5'd9;
      2'b10:   w = 5'd18;
      default: w = 5'd27;
    endcase
    return w;
  endfunction

  always_comb begin
    decoded = '0;
    for (int k = 0; k < N_phases; k++)
      decoded[5*k +: 5] = encode(phase_binary[2*k +: 2]);
  end

  always_comb begin
    field = '0;
    for (int k = 0; k < N_phases; k++)
      if (index == 2'(k)) field = phase_decimal[5*k +: 5];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      index         <= '0;
      phase_decimal <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      if (state == IDLE && load)
        phase_decimal <= decoded;
    end
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SEND;
          index_nxt = '0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = field;
        out_last  = (index == LAST);
        if (out_ready) begin
          if (index == LAST) begin
            state_nxt = DONE;
            index_nxt = '0;
          end else begin
            index_nxt = index + 2'd1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
      end
    endcase
  end

  assign out_index = index;
  assign busy      = (state != IDLE);

`ifdef PHASE_ENC_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (load && busy)
      overrun <= 1'b1;
  end
`endif

endmodule
